// File: rtl/onehot_encoder_seq.sv
// Sequential index encoder: accepts an M-bit select vector and emits the binary
// index of each active bit, lowest first, one beat per cycle with a last flag.
module onehot_encoder_seq #(
    parameter int   M      = 16,
    parameter int   N      = 4,
    parameter logic ACTIVE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sel,
    output logic         out_last,
    output logic         out_empty
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t         state_q, state_d;
    logic   [M-1:0] pend_q, pend_d;
    logic           empty_q, empty_d;

    logic   [M-1:0] norm_vec;
    logic   [M-1:0] pend_low_cleared;
    logic           pend_onehot;
    logic   [N-1:0] low_idx;
    logic           accept;
    logic           beat_done;

    assign norm_vec         = ACTIVE ? in_vec : ~in_vec;
    assign pend_low_cleared = pend_q & (pend_q - M'(1));
    assign pend_onehot      = (pend_q != '0) && (pend_low_cleared == '0);

    // Priority encoder: the downward scan leaves the lowest set index in low_idx.
    always_comb begin
        low_idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = N'(i);
            end
        end
    end

    // Outputs depend only on registered state, never on in_* directly.
    assign out_valid = (state_q == EMIT);
    assign out_empty = out_valid && empty_q;
    assign out_last  = out_valid && (empty_q || pend_onehot);
    assign out_sel   = (out_valid && !empty_q) ? low_idx : '0;

    assign beat_done = out_valid && out_ready;
    assign in_ready  = rst_n && ((state_q == IDLE) || (beat_done && out_last));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        empty_d = empty_q;
        if (beat_done) begin
            if (out_last) begin
                state_d = IDLE;
                pend_d  = '0;
                empty_d = 1'b0;
            end else begin
                pend_d = pend_low_cleared;
            end
        end
        // A new vector loaded on the last beat overrides the return to IDLE.
        if (accept) begin
            state_d = EMIT;
            pend_d  = norm_vec;
            empty_d = (norm_vec == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Directed bench for onehot_encoder_seq: an ACTIVE=1 and an ACTIVE=0 instance
// share the vector, reset and out_ready stimulus but have separate in_valid.
module tb_onehot_encoder_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_vec;
    logic        out_ready;

    logic        in_valid_a, in_ready_a, out_valid_a, out_last_a, out_empty_a;
    logic [3:0]  out_sel_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_last_b, out_empty_b;
    logic [3:0]  out_sel_b;

    int checks;
    int errors;

    onehot_encoder_seq #(.M(16), .N(4), .ACTIVE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_vec(in_vec),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sel(out_sel_a), .out_last(out_last_a), .out_empty(out_empty_a)
    );

    onehot_encoder_seq #(.M(16), .N(4), .ACTIVE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_vec(in_vec),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sel(out_sel_b), .out_last(out_last_b), .out_empty(out_empty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b0 || out_sel_a !== 4'd0 || out_last_a !== 1'b0 || out_empty_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b sel=%0d last=%b empty=%b expected 0/0/0/0",
                     out_valid_a, out_sel_a, out_last_a, out_empty_a);
        end
        checks++;
        if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready_low: got a=%b b=%b expected 0", in_ready_a, in_ready_b);
        end
        checks++;
        if (out_valid_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_b_valid: got %b expected 0", out_valid_b);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready_a);
        end
    endtask

    task automatic test_empty();
        in_vec     = 16'h0000;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        in_valid_a = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd0 || out_last_a !== 1'b1 || out_empty_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_beat: got valid=%b sel=%0d last=%b empty=%b expected 1/0/1/1",
                     out_valid_a, out_sel_a, out_last_a, out_empty_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_done: got valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_multi();
        int exp_sel [4] = '{0, 5, 10, 15};
        in_vec     = 16'h8421;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        in_valid_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (out_valid_a !== 1'b1 || out_sel_a !== 4'(exp_sel[j]) || out_last_a !== (j == 3) || out_empty_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL multi_beat %0d: got valid=%b sel=%0d last=%b empty=%b expected 1/%0d/%b/0",
                         j, out_valid_a, out_sel_a, out_last_a, out_empty_a, exp_sel[j], (j == 3));
            end
            checks++;
            if (in_ready_a !== (j == 3)) begin
                errors++;
                $display("[TB] FAIL multi_in_ready %0d: got %b expected %b", j, in_ready_a, (j == 3));
            end
            tick();
        end
        #1;
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multi_done: got valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_active_low();
        in_vec     = 16'hFFFB;
        in_valid_b = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        in_valid_b = 1'b0;
        #1;
        checks++;
        if (out_valid_b !== 1'b1 || out_sel_b !== 4'd2 || out_last_b !== 1'b1 || out_empty_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL active_low_beat: got valid=%b sel=%0d last=%b empty=%b expected 1/2/1/0",
                     out_valid_b, out_sel_b, out_last_b, out_empty_b);
        end
        tick();
        #1;
        checks++;
        if (out_valid_b !== 1'b0 || out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL active_low_done: got b=%b a=%b expected 0/0", out_valid_b, out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        in_vec     = 16'h0003;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        in_vec = 16'h0100;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd0 || out_last_a !== 1'b0 || in_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_beat0: got valid=%b sel=%0d last=%b in_ready=%b expected 1/0/0/0",
                     out_valid_a, out_sel_a, out_last_a, in_ready_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd1 || out_last_a !== 1'b1 || in_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_beat1: got valid=%b sel=%0d last=%b in_ready=%b expected 1/1/1/1",
                     out_valid_a, out_sel_a, out_last_a, in_ready_a);
        end
        tick();
        in_valid_a = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd8 || out_last_a !== 1'b1 || out_empty_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_beat2: got valid=%b sel=%0d last=%b empty=%b expected 1/8/1/0",
                     out_valid_a, out_sel_a, out_last_a, out_empty_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done: got valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_stall();
        in_vec     = 16'h0030;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        // Offer a different vector during the stall; it must not be sampled.
        in_vec    = 16'h0001;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (out_valid_a !== 1'b1 || out_sel_a !== 4'd4 || out_last_a !== 1'b0 || in_ready_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold %0d: got valid=%b sel=%0d last=%b in_ready=%b expected 1/4/0/0",
                         j, out_valid_a, out_sel_a, out_last_a, in_ready_a);
            end
            tick();
        end
        in_valid_a = 1'b0;
        out_ready  = 1'b1;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd4 || out_last_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_beat4: got valid=%b sel=%0d last=%b expected 1/4/0",
                     out_valid_a, out_sel_a, out_last_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd5 || out_last_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_beat5: got valid=%b sel=%0d last=%b expected 1/5/1",
                     out_valid_a, out_sel_a, out_last_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_done: got valid=%b expected 0", out_valid_a);
        end
    endtask

    task automatic test_reset_mid_emit();
        in_vec     = 16'hFFFF;
        in_valid_a = 1'b1;
        out_ready  = 1'b1;
        #1;
        tick();
        in_valid_a = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            #1;
            checks++;
            if (out_valid_a !== 1'b1 || out_sel_a !== 4'(j) || out_last_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL full_beat %0d: got valid=%b sel=%0d last=%b expected 1/%0d/0",
                         j, out_valid_a, out_sel_a, out_last_a, j);
            end
            if (j == 6) begin
                rst_n = 1'b0;
            end
            tick();
        end
        #1;
        checks++;
        if (out_valid_a !== 1'b0 || out_sel_a !== 4'd0 || out_last_a !== 1'b0 || in_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b sel=%0d last=%b in_ready=%b expected 0/0/0/0",
                     out_valid_a, out_sel_a, out_last_a, in_ready_a);
        end
        rst_n      = 1'b1;
        in_vec     = 16'h0002;
        in_valid_a = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got in_ready=%b valid=%b expected 1/0", in_ready_a, out_valid_a);
        end
        tick();
        in_valid_a = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'd1 || out_last_a !== 1'b1 || out_empty_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_beat: got valid=%b sel=%0d last=%b empty=%b expected 1/1/1/0",
                     out_valid_a, out_sel_a, out_last_a, out_empty_a);
        end
        tick();
        #1;
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_done: got valid=%b expected 0", out_valid_a);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in_vec     = '0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_empty();
        test_multi();
        test_active_low();
        test_back_to_back();
        test_stall();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
